// File: rtl/b_registered_dsp_stimulus_checker_if.sv
// Operand/result bus between the stimulus checker and the registered-input DSP multiply wrapper.
interface b_registered_dsp_stimulus_checker_if;
   logic [19:0] a;
   logic [17:0] b;
   logic [37:0] z_out;
   logic [17:0] dly_b;

   modport master (output a, output b, input z_out, input dly_b);
   modport slave  (input a, input b, output z_out, output dly_b);
endinterface

// File: rtl/b_registered_dsp_stimulus_checker.sv
// On-chip self-test for the DSP multiply wrapper: LFSR operands out, golden pipeline
// scoreboard on z_out/dly_b, pass/fail summary with the first failing vector captured.
module b_registered_dsp_stimulus_checker #(
   parameter int          RESULT_LATENCY = 1,
   parameter int          DLY_B_LATENCY  = 1,
   parameter int          CNT_W          = 16,
   parameter logic [19:0] SEED_A         = 20'h00001,
   parameter logic [17:0] SEED_B         = 18'h00001
) (
   input  logic                                 clock0,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [CNT_W-1:0]                     num_vectors,
   b_registered_dsp_stimulus_checker_if.master  dsp,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 pass,
   output logic [CNT_W-1:0]                     err_count,
   output logic [CNT_W-1:0]                     first_err_idx,
   output logic [37:0]                          first_err_z
);

   localparam int MAX_LAT = (RESULT_LATENCY > DLY_B_LATENCY) ? RESULT_LATENCY : DLY_B_LATENCY;
   localparam logic [19:0] SEED_A_NZ = (SEED_A == 20'h0) ? 20'h00001 : SEED_A;
   localparam logic [17:0] SEED_B_NZ = (SEED_B == 18'h0) ? 18'h00001 : SEED_B;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic             valid;
      logic [CNT_W-1:0] idx;
      logic [37:0]      prod;
      logic [17:0]      b;
      logic             z_bad;
      logic             b_bad;
      logic [37:0]      z_seen;
   } entry_t;

   state_t           state;
   logic [19:0]      lfsr_a;
   logic [17:0]      lfsr_b;
   logic [19:0]      a_q;
   logic [17:0]      b_q;
   logic [CNT_W-1:0] vec_cnt;
   logic [CNT_W-1:0] num_q;

   entry_t pipe     [0:MAX_LAT];
   entry_t pipe_upd [0:MAX_LAT];
   entry_t push_entry;
   entry_t tail;
   logic             pipe_busy;
   logic             vec_fail;
   logic [CNT_W-1:0] err_next;

   assign dsp.a = a_q;
   assign dsp.b = b_q;

   always_comb begin
      push_entry        = '0;
      push_entry.valid  = (state == RUN);
      push_entry.idx    = vec_cnt;
      push_entry.prod   = {18'b0, lfsr_a} * {20'b0, lfsr_b};
      push_entry.b      = lfsr_b;
   end

   // Each stream grades its entry at its own tap; the verdict is read at the deepest
   // stage, so z and dly_b results for one idx always meet in the same entry.
   always_comb begin
      for (int j = 0; j <= MAX_LAT; j++) begin
         pipe_upd[j] = pipe[j];
         if (j == RESULT_LATENCY && pipe[j].valid) begin
            pipe_upd[j].z_bad  = (dsp.z_out != pipe[j].prod);
            pipe_upd[j].z_seen = dsp.z_out;
         end
         if (j == DLY_B_LATENCY && pipe[j].valid) begin
            pipe_upd[j].b_bad = (dsp.dly_b != pipe[j].b);
         end
      end
   end

   always_comb begin
      pipe_busy = 1'b0;
      for (int j = 0; j < MAX_LAT; j++) begin
         pipe_busy = pipe_busy | pipe[j].valid;
      end
   end

   assign tail     = pipe_upd[MAX_LAT];
   assign vec_fail = tail.valid && (tail.z_bad || tail.b_bad);
   assign err_next = (vec_fail && (err_count != '1)) ? err_count + 1'b1 : err_count;

   always_ff @(posedge clock0 or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j <= MAX_LAT; j++) begin
            pipe[j] <= '0;
         end
      end else begin
         pipe[0] <= push_entry;
         for (int j = 1; j <= MAX_LAT; j++) begin
            pipe[j] <= pipe_upd[j-1];
         end
      end
   end

   always_ff @(posedge clock0 or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         lfsr_a        <= SEED_A_NZ;
         lfsr_b        <= SEED_B_NZ;
         a_q           <= '0;
         b_q           <= '0;
         vec_cnt       <= '0;
         num_q         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
         first_err_z   <= '0;
      end else begin
         if (vec_fail) begin
            err_count <= err_next;
            if (err_count == '0) begin
               first_err_idx <= tail.idx;
               first_err_z   <= tail.z_seen;
            end
         end

         case (state)
            IDLE: begin
               a_q <= '0;
               b_q <= '0;
               if (start) begin
                  err_count     <= '0;
                  first_err_idx <= '0;
                  first_err_z   <= '0;
                  lfsr_a        <= SEED_A_NZ;
                  lfsr_b        <= SEED_B_NZ;
                  vec_cnt       <= '0;
                  num_q         <= num_vectors;
                  if (num_vectors == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end
            end

            RUN: begin
               a_q     <= lfsr_a;
               b_q     <= lfsr_b;
               lfsr_a  <= {lfsr_a[18:0], lfsr_a[19] ^ lfsr_a[16]};
               lfsr_b  <= {lfsr_b[16:0], lfsr_b[17] ^ lfsr_b[10]};
               vec_cnt <= vec_cnt + 1'b1;
               if (vec_cnt == num_q - 1'b1) begin
                  state <= DRAIN;
               end
            end

            // Leave once only the deepest stage is still occupied: its verdict lands this edge.
            DRAIN: begin
               a_q <= '0;
               b_q <= '0;
               if (!pipe_busy) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end
            end

            DONE: begin
               a_q   <= '0;
               b_q   <= '0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_b_registered_dsp_stimulus_checker.sv
// Directed bench: ideal/faulty DSP wrapper models around two checker instances.
module tb_b_registered_dsp_stimulus_checker;

   logic        clock0;
   logic        reset;
   logic        start;
   logic [15:0] num_vectors;
   logic        busy, done, pass;
   logic [15:0] err_count, first_err_idx;
   logic [37:0] first_err_z;

   logic        start5;
   logic [15:0] num5;
   logic        busy5, done5, pass5;
   logic [15:0] err5, idx5;
   logic [37:0] z5;

   logic        flip_z, stuck_b;
   logic [19:0] a_r, a5_r;
   logic [17:0] b_r, b5_r;

   int compared   = 0;
   int mismatched = 0;

   b_registered_dsp_stimulus_checker_if bus ();
   b_registered_dsp_stimulus_checker_if bus5 ();

   b_registered_dsp_stimulus_checker dut (
      .clock0(clock0), .reset(reset), .start(start), .num_vectors(num_vectors),
      .dsp(bus.master), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_idx(first_err_idx), .first_err_z(first_err_z));

   b_registered_dsp_stimulus_checker #(.SEED_A(20'hFFFFF), .SEED_B(18'h3FFFF)) dut5 (
      .clock0(clock0), .reset(reset), .start(start5), .num_vectors(num5),
      .dsp(bus5.master), .busy(busy5), .done(done5), .pass(pass5),
      .err_count(err5), .first_err_idx(idx5), .first_err_z(z5));

   initial clock0 = 1'b0;
   always #5 clock0 = ~clock0;

   // Ideal registered-input multiplier, with optional z bit-flip on a==8 and stuck dly_b.
   always_ff @(posedge clock0 or negedge reset) begin
      if (!reset) begin
         a_r <= '0; b_r <= '0; a5_r <= '0; b5_r <= '0;
      end else begin
         a_r <= bus.a; b_r <= bus.b; a5_r <= bus5.a; b5_r <= bus5.b;
      end
   end

   assign bus.z_out  = ({18'b0, a_r} * {20'b0, b_r}) ^ {37'b0, (flip_z && a_r == 20'd8)};
   assign bus.dly_b  = stuck_b ? 18'b0 : b_r;
   assign bus5.z_out = {18'b0, a5_r} * {20'b0, b5_r};
   assign bus5.dly_b = b5_r;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [15:0] n);
      @(negedge clock0);
      num_vectors = n;
      start = 1'b1;
      @(negedge clock0);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 40 && !done; i++) @(negedge clock0);
      check_output(tag, {63'b0, done}, 64'd1);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; num_vectors = '0; start5 = 1'b0; num5 = '0;
      flip_z = 1'b0; stuck_b = 1'b0;
      #12;
      check_output("rst_a", {44'b0, bus.a}, 64'd0);
      check_output("rst_b", {46'b0, bus.b}, 64'd0);
      check_output("rst_flags", {61'b0, busy, done, pass}, 64'd0);
      check_output("rst_err", {48'b0, err_count}, 64'd0);
      check_output("rst_idx", {48'b0, first_err_idx}, 64'd0);
      check_output("rst_z", {26'b0, first_err_z}, 64'd0);
      @(negedge clock0);
      reset = 1'b1;

      $display("[TB] test 1: ideal DSP, 8 vectors");
      apply_stimulus(16'd8);
      check_output("t1_busy", {63'b0, busy}, 64'd1);
      check_output("t1_a_pre", {44'b0, bus.a}, 64'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clock0);
         check_output($sformatf("t1_a%0d", k), {44'b0, bus.a}, 64'd1 << k);
         check_output($sformatf("t1_b%0d", k), {46'b0, bus.b}, 64'd1 << k);
      end
      @(negedge clock0);
      check_output("t1_drain", {44'b0, bus.a, 1'b0, busy} & 64'h1FFFFF1, 64'd1);
      wait_done("t1_done");
      check_output("t1_pass", {63'b0, pass}, 64'd1);
      check_output("t1_err", {48'b0, err_count}, 64'd0);
      repeat (3) @(negedge clock0);
      check_output("t1_done_held", {62'b0, done, busy}, 64'd2);

      $display("[TB] test 2: z_out[0] flipped on vector 3");
      flip_z = 1'b1;
      apply_stimulus(16'd8);
      check_output("t2_done_clr", {63'b0, done}, 64'd0);
      wait_done("t2_done");
      check_output("t2_err", {48'b0, err_count}, 64'd1);
      check_output("t2_idx", {48'b0, first_err_idx}, 64'd3);
      check_output("t2_z", {26'b0, first_err_z}, 64'h41);
      check_output("t2_pass", {63'b0, pass}, 64'd0);
      flip_z = 1'b0;

      $display("[TB] test 3: dly_b stuck at 0");
      stuck_b = 1'b1;
      apply_stimulus(16'd4);
      wait_done("t3_done");
      check_output("t3_err", {48'b0, err_count}, 64'd4);
      check_output("t3_idx", {48'b0, first_err_idx}, 64'd0);
      check_output("t3_z", {26'b0, first_err_z}, 64'd1);
      check_output("t3_pass", {63'b0, pass}, 64'd0);
      stuck_b = 1'b0;

      $display("[TB] test 4: zero vectors");
      apply_stimulus(16'd0);
      check_output("t4_done", {63'b0, done}, 64'd1);
      check_output("t4_pass", {63'b0, pass}, 64'd1);
      check_output("t4_busy", {63'b0, busy}, 64'd0);
      check_output("t4_err", {48'b0, err_count}, 64'd0);

      $display("[TB] test 5: all-ones seeds");
      @(negedge clock0);
      num5 = 16'd1; start5 = 1'b1;
      @(negedge clock0);
      start5 = 1'b0;
      @(negedge clock0);
      check_output("t5_a", {44'b0, bus5.a}, 64'hFFFFF);
      check_output("t5_b", {46'b0, bus5.b}, 64'h3FFFF);
      @(negedge clock0);
      check_output("t5_z", {26'b0, bus5.z_out}, 64'h3FFFEC0001);
      for (int i = 0; i < 20 && !done5; i++) @(negedge clock0);
      check_output("t5_done", {63'b0, done5}, 64'd1);
      check_output("t5_pass", {63'b0, pass5}, 64'd1);

      $display("[TB] test 6: start ignored in RUN, async reset mid-run");
      apply_stimulus(16'd8);
      @(negedge clock0);
      @(negedge clock0);
      check_output("t6_a2", {44'b0, bus.a}, 64'd2);
      num_vectors = 16'd0; start = 1'b1;
      @(negedge clock0);
      start = 1'b0;
      check_output("t6_a4", {44'b0, bus.a}, 64'd4);
      check_output("t6_busy", {62'b0, busy, done}, 64'd2);
      #2 reset = 1'b0;
      #1;
      check_output("t6_rst_ab", {26'b0, bus.a, bus.b}, 64'd0);
      check_output("t6_rst_flags", {62'b0, busy, done}, 64'd0);
      @(negedge clock0);
      reset = 1'b1;
      @(negedge clock0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
